conv_stream_engine: RTL

- Parametrised successor of the clk2-domain convolution engine.
- Collects one image and NUM_KER square kernels from the handshake synchroniser's destination port, one beat per in_valid pulse.
- Computes a valid-mode 2-D convolution per kernel with run-time stride 1 or 2.
- Streams results into the async FIFO under fifo_full backpressure, with optional saturation to OUT_W.

---
 rtl/conv_pkg.sv | 44 ++++
 rtl/conv_window_mac.sv | 39 +++
 rtl/conv_stream_engine.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// conv_pkg
// Shared definitions for the streaming convolution engine: the job state
// enum and the width/geometry helper functions used to derive the
// beat width, accumulator width and output side length from the
// engine parameters.
package conv_pkg;

  typedef enum logic [1:0] {
    LOAD,
    PRIME,
    STREAM
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int width_f(input int n);
    return (n <= 1) ? 1 : clog2_f(n);
  endfunction

  function automatic int in_w_f(input int img_n, input int ker_k, input int pix_w);
    return img_n * pix_w + ker_k * ker_k * pix_w;
  endfunction

  function automatic int beats_f(input int img_n, input int num_ker);
    return (img_n > num_ker) ? img_n : num_ker;
  endfunction

  function automatic int acc_w_f(input int pix_w, input int ker_k);
    return 2 * pix_w + clog2_f(ker_k * ker_k);
  endfunction

  // Valid-mode output side length for stride s (floor division).
  function automatic int od_f(input int img_n, input int ker_k, input int s);
    return (img_n - ker_k) / s + 1;
  endfunction

endpackage

// File: rtl/conv_window_mac.sv
// conv_window_mac
// Combinational multiply-accumulate of one KER_K x KER_K pixel window
// against one kernel, followed by saturation to OUT_W bits.
// Ports:
//   window  in   KER_K*KER_K pixels, element 0 first (MSB side)
//   kernel  in   KER_K*KER_K kernel elements, same ordering as window
//   result  out  sum of products, clamped to 2^OUT_W-1
module conv_window_mac
  import conv_pkg::*;
#(
  parameter int KER_K = 2,
  parameter int PIX_W = 3,
  parameter int OUT_W = 8
) (
  input  logic [0:KER_K*KER_K-1][PIX_W-1:0] window,
  input  logic [0:KER_K*KER_K-1][PIX_W-1:0] kernel,
  output logic [OUT_W-1:0]                  result
);

  localparam int KK    = KER_K * KER_K;
  localparam int ACC_W = acc_w_f(PIX_W, KER_K);

  logic [ACC_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int e = 0; e < KK; e++) begin
      acc = acc + ACC_W'(window[e]) * ACC_W'(kernel[e]);
    end
  end

  // Saturation logic only exists when the accumulator can exceed OUT_W.
  if (ACC_W > OUT_W) begin : g_sat
    assign result = (|acc[ACC_W-1:OUT_W]) ? '1 : acc[OUT_W-1:0];
  end else begin : g_ext
    assign result = OUT_W'(acc);
  end

endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine
// Loads one image plus NUM_KER kernels over BEATS handshake beats, then
// streams a valid-mode 2-D convolution per kernel (stride 1 or 2) into
// an async FIFO, holding under fifo_full backpressure.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    one load beat per pulse (ignored while busy)
//   in_data     {image row b, kernel b}, pixel/element 0 in the MSBs
//   stride2     stride select, sampled on beat 0
//   busy        high while computing or streaming a job
//   fifo_full   FIFO write-side full
//   out_valid   result write strobe
//   out_data    result word (0 when out_valid is low)
//   done        one-cycle pulse after the last result is accepted
module conv_stream_engine
  import conv_pkg::*;
#(
  parameter int IMG_N   = 6,
  parameter int KER_K   = 2,
  parameter int NUM_KER = 6,
  parameter int PIX_W   = 3,
  parameter int OUT_W   = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  input  logic [in_w_f(IMG_N,KER_K,PIX_W)-1:0]    in_data,
  input  logic                                    stride2,
  output logic                                    busy,
  input  logic                                    fifo_full,
  output logic                                    out_valid,
  output logic [OUT_W-1:0]                        out_data,
  output logic                                    done
);

  localparam int IN_W   = in_w_f(IMG_N, KER_K, PIX_W);
  localparam int KK     = KER_K * KER_K;
  localparam int KER_W  = KK * PIX_W;
  localparam int BEATS  = beats_f(IMG_N, NUM_KER);
  localparam int BEAT_W = width_f(BEATS);
  localparam int RC_W   = width_f(IMG_N);
  localparam int K_W    = width_f(NUM_KER);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [K_W-1:0]    LAST_K    = K_W'(NUM_KER - 1);
  localparam logic [RC_W-1:0]   LAST_RC1  = RC_W'(od_f(IMG_N, KER_K, 1) - 1);
  localparam logic [RC_W-1:0]   LAST_RC2  = RC_W'(od_f(IMG_N, KER_K, 2) - 1);

  state_t state, state_nxt;

  logic [BEAT_W-1:0] beat;
  logic              stride_r;
  logic [K_W-1:0]    k_cnt, k_nxt, k_sel;
  logic [RC_W-1:0]   r_cnt, r_nxt, r_sel;
  logic [RC_W-1:0]   c_cnt, c_nxt, c_sel;
  logic [RC_W-1:0]   last_rc, row_base, col_base;
  logic [OUT_W-1:0]  res_r, mac_out;
  logic              load_beat, accept, last_pos;

  logic [0:IMG_N-1][PIX_W-1:0] img_mem [IMG_N];
  logic [0:KK-1][PIX_W-1:0]    ker_mem [NUM_KER];
  logic [0:KK-1][PIX_W-1:0]    window;

  assign load_beat = (state == LOAD) && in_valid;
  assign accept    = (state == STREAM) && !fifo_full;
  assign last_rc   = stride_r ? LAST_RC2 : LAST_RC1;
  assign last_pos  = (k_cnt == LAST_K) && (r_cnt == last_rc) && (c_cnt == last_rc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_beat && beat == LAST_BEAT) state_nxt = PRIME;
      PRIME:   state_nxt = STREAM;
      STREAM:  if (accept && last_pos) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    busy      = (state != LOAD);
    out_valid = (state == STREAM) && !fifo_full;
    out_data  = out_valid ? res_r : '0;
  end

  // Index successor in c-fastest, then r, then k order; wraps to (0,0,0)
  // after the final position so the counters are already cleared for PRIME.
  always_comb begin
    c_nxt = c_cnt + 1'b1;
    r_nxt = r_cnt;
    k_nxt = k_cnt;
    if (c_cnt == last_rc) begin
      c_nxt = '0;
      r_nxt = r_cnt + 1'b1;
      if (r_cnt == last_rc) begin
        r_nxt = '0;
        k_nxt = (k_cnt == LAST_K) ? '0 : k_cnt + 1'b1;
      end
    end
  end

  // The single MAC looks ahead to the next position on an accepted word so
  // res_r is refreshed on the same edge; otherwise it sees the current one.
  assign k_sel    = accept ? k_nxt : k_cnt;
  assign r_sel    = accept ? r_nxt : r_cnt;
  assign c_sel    = accept ? c_nxt : c_cnt;
  assign row_base = r_sel << stride_r;
  assign col_base = c_sel << stride_r;

  for (genvar gi = 0; gi < KER_K; gi++) begin : g_row
    for (genvar gj = 0; gj < KER_K; gj++) begin : g_col
      assign window[gi*KER_K+gj] = img_mem[row_base + RC_W'(gi)][col_base + RC_W'(gj)];
    end
  end

  conv_window_mac #(
    .KER_K (KER_K),
    .PIX_W (PIX_W),
    .OUT_W (OUT_W)
  ) u_mac (
    .window (window),
    .kernel (ker_mem[k_sel]),
    .result (mac_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat     <= '0;
      stride_r <= 1'b0;
      k_cnt    <= '0;
      r_cnt    <= '0;
      c_cnt    <= '0;
      res_r    <= '0;
      done     <= 1'b0;
    end else begin
      if (load_beat) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
        if (beat == '0) stride_r <= stride2;
      end
      if (state == PRIME || accept) res_r <= mac_out;
      if (accept) begin
        k_cnt <= k_nxt;
        r_cnt <= r_nxt;
        c_cnt <= c_nxt;
      end
      done <= accept && last_pos;
    end
  end

  // Operand storage survives reset; every job rewrites it from beat 0.
  always_ff @(posedge clk) begin
    if (load_beat) begin
      if (int'(beat) < IMG_N)   img_mem[RC_W'(beat)] <= in_data[IN_W-1 -: IMG_N*PIX_W];
      if (int'(beat) < NUM_KER) ker_mem[K_W'(beat)]  <= in_data[KER_W-1:0];
    end
  end

endmodule
